// File: rtl/tpu_mac_unit_pe.sv
// Systolic-array PE: stationary weight, INT8 / FP16 / FP32 multiply or multiply-accumulate
// with saturating INT results, truncating (round-toward-zero) FP and registered forwarding.
module tpu_mac_unit_pe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            data_type,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] c_in,
    input  logic                  load_weight,
    input  logic                  accumulate,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] c_out,
    output logic                  overflow,
    output logic                  underflow
);

    typedef enum logic [1:0] {DT_INT8 = 2'b00, DT_FP16 = 2'b01, DT_FP32 = 2'b10, DT_RSVD = 2'b11} data_type_e;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        unf;
    } fp_res_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic [31:0] flush_fp32(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? {x[31], 31'd0} : x;
    endfunction

    function automatic logic [31:0] widen_fp16(input logic [15:0] h);
        logic [31:0] r;
        r = {h[15], 8'd112 + {3'b000, h[14:10]}, h[9:0], 13'd0};
        if (h[14:10] == 5'h00)      r = {h[15], 31'd0};
        else if (h[14:10] == 5'h1F) r = {h[15], 8'hFF, h[9:0], 13'd0};
        return r;
    endfunction

    // Packs an already truncated significand; biased exponent may be out of range either way.
    function automatic fp_res_t pack(input logic s, input logic signed [10:0] e, input logic [22:0] m);
        fp_res_t r;
        r.val = {s, e[7:0], m};
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (e > 11'sd254) begin
            r.val = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (e < 11'sd1) begin
            r.val = {s, 31'd0};
            r.unf = 1'b1;
        end
        return r;
    endfunction

    function automatic fp_res_t fp_mul(input logic [31:0] x, input logic [31:0] y);
        fp_res_t            r;
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        s     = x[31] ^ y[31];
        r.val = {s, 31'd0};
        r.ovf = 1'b0;
        r.unf = 1'b0;
        p     = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e     = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
        if (is_nan(x) || is_nan(y) || (is_inf(x) && y[30:0] == 31'd0) || (is_inf(y) && x[30:0] == 31'd0))
            r.val = QNAN;
        else if (is_inf(x) || is_inf(y))
            r.val = {s, 8'hFF, 23'd0};
        else if (x[30:0] != 31'd0 && y[30:0] != 31'd0)
            r = pack(s, p[47] ? e + 11'sd1 : e, p[47] ? p[46:24] : p[45:23]);
        return r;
    endfunction

    // One guard bit suffices for truncation: the smaller addend is floored when adding and
    // ceiled when subtracting, so the truncated sum matches the truncated exact result.
    function automatic fp_res_t fp_add(input logic [31:0] x, input logic [31:0] y);
        fp_res_t            r;
        logic [31:0]        big, sml;
        logic [7:0]         d;
        logic [49:0]        wide;
        logic [25:0]        ma, mb, sum, norm;
        logic [4:0]         lead;
        logic               sub;
        logic signed [10:0] e;
        r.val = x;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        sub  = x[31] ^ y[31];
        d    = big[30:23] - sml[30:23];
        wide = {1'b1, sml[22:0], 1'b0, 25'd0} >> ((d > 8'd26) ? 8'd26 : d);
        ma   = {2'b01, big[22:0], 1'b0};
        mb   = {1'b0, wide[49:25]} + (sub ? {25'd0, |wide[24:0]} : 26'd0);
        sum  = sub ? ma - mb : ma + mb;
        lead = 5'd0;
        for (int i = 0; i < 26; i++)
            if (sum[i]) lead = 5'(i);
        norm = sum << (5'd25 - lead);
        e    = $signed({3'b000, big[30:23]}) + $signed({6'b000000, lead}) - 11'sd24;
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && sub))
            r.val = QNAN;
        else if (is_inf(big))
            r.val = big;
        else if (sml[30:0] == 31'd0)
            r.val = (big[30:0] == 31'd0) ? {x[31] & y[31], 31'd0} : big;
        else if (sum == 26'd0)
            r.val = 32'd0;
        else
            r = pack(big[31], e, norm[24:2]);
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] w_q, a_q, b_q, c_q, c_d;
    logic                  ovf_q, unf_q, ovf_d, unf_d;
    logic [31:0]           w_eff, op_a, op_w, op_c;
    logic signed [15:0]    a8, w8, int_prod;
    logic signed [32:0]    int_sum;
    fp_res_t               prod_r, add_r;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        w_eff    = load_weight ? b_in : w_q;
        a8       = 16'($signed(a_in[7:0]));
        w8       = 16'($signed(w_eff[7:0]));
        int_prod = a8 * w8;
        int_sum  = 33'(int_prod) + (accumulate ? 33'($signed(c_in)) : 33'sd0);
        op_a     = (data_type == DT_FP16) ? widen_fp16(a_in[15:0])  : flush_fp32(a_in);
        op_w     = (data_type == DT_FP16) ? widen_fp16(w_eff[15:0]) : flush_fp32(w_eff);
        op_c     = flush_fp32(c_in);
        prod_r   = fp_mul(op_a, op_w);
        add_r    = fp_add(prod_r.val, op_c);
        c_d      = int_sum[31:0];
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (data_type == DT_FP16 || data_type == DT_FP32) begin
            if (!accumulate) begin
                c_d   = prod_r.val;
                ovf_d = prod_r.ovf;
                unf_d = prod_r.unf;
            end else begin
                c_d   = add_r.val;
                ovf_d = add_r.ovf | (prod_r.ovf & is_inf(add_r.val));
                unf_d = add_r.unf | (prod_r.unf & (add_r.val[30:0] == 31'd0));
            end
        end else if (int_sum[32:31] == 2'b01) begin
            c_d   = 32'h7FFF_FFFF;
            ovf_d = 1'b1;
        end else if (int_sum[32:31] == 2'b10) begin
            c_d   = 32'h8000_0000;
            unf_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (enable) begin
            if (load_weight) w_q <= b_in;
            a_q   <= a_in;
            b_q   <= b_in;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign c_out     = c_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_tpu_mac_unit_pe.sv
// Directed bench for tpu_mac_unit_pe: vector table plus hand sequences for accumulation,
// enable hold, periodic weight loads and mid-stream reset.
module tb_tpu_mac_unit_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  data_type;
    logic [31:0] a_in, b_in, c_in;
    logic        load_weight, accumulate;
    logic [31:0] a_out, b_out, c_out;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;

    tpu_mac_unit_pe #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .data_type   (data_type),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .load_weight (load_weight),
        .accumulate  (accumulate),
        .a_out       (a_out),
        .b_out       (b_out),
        .c_out       (c_out),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dt;
        logic        lw;
        logic        acc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_c;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string name, input logic [31:0] ec, input logic eo, input logic eu,
                             input logic [31:0] ea, input logic [31:0] eb);
        check({name, " c_out"},     c_out,          ec);
        check({name, " overflow"},  32'(overflow),  32'(eo));
        check({name, " underflow"}, 32'(underflow), 32'(eu));
        check({name, " a_out"},     a_out,          ea);
        check({name, " b_out"},     b_out,          eb);
    endtask

    task automatic drive(input logic en, input logic [1:0] dt, input logic lw, input logic ac,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        enable      = en;
        data_type   = dt;
        load_weight = lw;
        accumulate  = ac;
        a_in        = a;
        b_in        = b;
        c_in        = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          dt    lw    acc   a             b             c             exp_c         ovf   unf
        vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 1'b0, 1'b0, 32'h0000_00FE, 32'h0000_0077, 32'h0000_0000, 32'hFFFF_FFFA, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 1'b1, 1'b1, 32'h0000_007F, 32'h0000_007F, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0081, 32'h0000_0000, 32'h8000_0005, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4]  = '{2'd3, 1'b1, 1'b1, 32'hABCD_FF80, 32'h1234_5680, 32'h0000_0064, 32'h0000_4064, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_007F, 32'h0000_0000, 32'hFFFF_C080, 1'b0, 1'b0};
        vecs[6]  = '{2'd0, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1};
        vecs[9]  = '{2'd2, 1'b1, 1'b0, 32'h4040_0000, 32'h4000_0000, 32'h0000_0000, 32'h40C0_0000, 1'b0, 1'b0};
        vecs[10] = '{2'd1, 1'b1, 1'b0, 32'hDEAD_4200, 32'hBEEF_4000, 32'h0000_0000, 32'h40C0_0000, 1'b0, 1'b0};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0};
        vecs[12] = '{2'd2, 1'b1, 1'b0, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{2'd2, 1'b1, 1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
        vecs[14] = '{2'd2, 1'b1, 1'b1, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h40E0_0000, 1'b0, 1'b0};
        vecs[15] = '{2'd2, 1'b1, 1'b1, 32'h4040_0000, 32'h4000_0000, 32'hC0C0_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[16] = '{2'd2, 1'b1, 1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
        vecs[17] = '{2'd2, 1'b1, 1'b0, 32'h7F80_0000, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0};
        vecs[18] = '{2'd2, 1'b1, 1'b1, 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0};
        vecs[19] = '{2'd2, 1'b1, 1'b0, 32'h3FC0_0001, 32'h3FC0_0001, 32'h0000_0000, 32'h4010_0001, 1'b0, 1'b0};
        vecs[20] = '{2'd2, 1'b1, 1'b1, 32'hB300_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F7F_FFFF, 1'b0, 1'b0};
        vecs[21] = '{2'd1, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_3C00, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[22] = '{2'd1, 1'b1, 1'b0, 32'h0000_7C00, 32'h0000_4000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0};
        vecs[23] = '{2'd2, 1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0};
        vecs[24] = '{2'd2, 1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0005, 32'h0000_0000, 32'h4000_0005, 1'b0, 1'b0};
        vecs[25] = '{2'd0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) step();
        check_all("reset", 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 26; i++) begin
            drive(1'b1, vecs[i].dt, vecs[i].lw, vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].c);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_ovf, vecs[i].exp_unf,
                      vecs[i].a, vecs[i].b);
        end

        // 100-cycle accumulation chain fed back from c_out
        begin
            int flag_hits = 0;
            drive(1'b1, 2'd0, 1'b1, 1'b0, 32'd5, 32'd3, 32'd0);
            step();
            check("chain start c_out", c_out, 32'd15);
            for (int i = 0; i < 100; i++) begin
                drive(1'b1, 2'd0, 1'b0, 1'b1, 32'd2, 32'h0000_00EE, c_out);
                step();
                if (overflow || underflow) flag_hits++;
            end
            check("chain final c_out", c_out, 32'd615);
            check("chain flag cycles", 32'(flag_hits), 32'd0);
        end

        // Enable low holds state and clears flags; load_weight ignored while disabled
        drive(1'b1, 2'd0, 1'b1, 1'b1, 32'h7F, 32'h7F, 32'h7FFF_FFF0);
        step();
        check_all("pre-hold", 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7F, 32'h7F);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'(k), 1'b1, 1'b1, 32'h100 + 32'(k), 32'd9 + 32'(k), 32'h5555_0000 + 32'(k));
            step();
            check_all($sformatf("hold%0d", k), 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h7F, 32'h7F);
        end
        drive(1'b1, 2'd0, 1'b0, 1'b0, 32'd2, 32'h0000_0011, 32'd0);
        step();
        check_all("post-hold", 32'd254, 1'b0, 1'b0, 32'd2, 32'h11);

        // 1000 nonzero INT8 ops, new weight on every 10th
        begin
            int av, wv, cur_w;
            cur_w = 1;
            for (int i = 0; i < 1000; i++) begin
                av = ((i * 7) % 255) - 127;
                if (av == 0) av = 1;
                wv = (((i / 10) * 13) % 255) - 127;
                if (wv == 0) wv = -1;
                if (i % 10 == 0) begin
                    cur_w = wv;
                    drive(1'b1, 2'd0, 1'b1, 1'b0, {24'hA5A5A5, av[7:0]}, {24'h3C3C3C, wv[7:0]}, 32'h1234_5678);
                end else begin
                    drive(1'b1, 2'd0, 1'b0, 1'b0, {24'hA5A5A5, av[7:0]}, 32'h0000_0040 + 32'(i), 32'h1234_5678);
                end
                step();
                check($sformatf("wload%0d c_out", i), c_out, 32'(av * cur_w));
            end
        end

        // Mid-stream asynchronous reset
        drive(1'b1, 2'd0, 1'b1, 1'b0, 32'd6, 32'd7, 32'd0);
        step();
        check("pre-reset c_out", c_out, 32'd42);
        #2 rst_n = 1'b0;
        #1;
        check_all("async reset", 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 32'd4, 32'h99, 32'd0);
        step();
        check_all("post-reset W=0", 32'd0, 1'b0, 1'b0, 32'd4, 32'h99);
        drive(1'b1, 2'd0, 1'b1, 1'b0, 32'd4, 32'd5, 32'd0);
        step();
        check_all("post-reset load", 32'd20, 1'b0, 1'b0, 32'd4, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tpu_mac_unit_pe.md
Name: tpu_mac_unit_pe

Overview:
- Single processing element (PE) of the TPU systolic array.
- Holds a stationary weight and computes one multiply, or multiply-accumulate, per enabled clock: c_out = a_in*W or c_in + a_in*W.
- Forwards activation and weight operands to neighbouring PEs through registered pass-through outputs.
- Supports INT8, FP16 and FP32 operands, with saturation/overflow and underflow flags.

Parameters:
- DATA_WIDTH, 32, width of a/b/c buses. Datapath rules below assume 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  when 1, the PE updates on this edge; when 0, all registers hold and flags clear.
- data_type  in  2  00=INT8, 01=FP16, 10=FP32, 11=reserved (processed as INT8).
- a_in  in  DATA_WIDTH  activation operand.
- b_in  in  DATA_WIDTH  weight operand.
- c_in  in  DATA_WIDTH  partial-sum input.
- a_out  out  DATA_WIDTH  registered a_in (to right neighbour).
- b_out  out  DATA_WIDTH  registered b_in (to lower neighbour).
- c_out  out  DATA_WIDTH  registered MAC result.
- load_weight  in  1  when 1 with enable, capture b_in as the stationary weight W.
- accumulate  in  1  1: add c_in to product; 0: product only.
- overflow  out  1  registered; result saturated/infinite this update.
- underflow  out  1  registered; result saturated-negative (INT) or flushed (FP) this update.

Behaviour:
- Reset (async, rst_n=0): W, a_out, b_out, c_out, overflow and underflow all go to 0.

Latency and update rules (1 cycle):
- Operands sampled at the rising edge with enable=1.
- c_out, a_out, b_out and the flags are valid after that edge.
- Back-to-back operation every cycle; no stall or handshake.
- Weight selection: Weff = b_in if load_weight=1, else W. A newly loaded weight is used in the same cycle's product.
- On load_weight=1 (with enable=1), W <= b_in.
- a_out <= a_in and b_out <= b_in on every enabled edge.
- enable=0: W, a_out, b_out, c_out hold; overflow and underflow <= 0; load_weight is ignored.

INT8 (data_type 00/11):
- Product: signed a_in[7:0] × signed Weff[7:0], giving a 16-bit result sign-extended to 32 bits.
- Sum: product + (accumulate ? signed c_in : 0), computed in 33 bits.
- If the sum > 0x7FFFFFFF: c_out = 0x7FFFFFFF, overflow = 1.
- If the sum < 0x80000000 (signed): c_out = 0x80000000, underflow = 1.
- Otherwise c_out = sum and both flags 0.

FP16 (data_type 01):
- a_in[15:0] and Weff[15:0] are IEEE half values.
- Both are widened exactly to FP32, with half denormals flushed to signed zero.
- The operation then proceeds as FP32 below; c_in and c_out are FP32.

FP32 (data_type 10):
- Operands: IEEE single; c_in is FP32.
- Product first, rounded toward zero. If accumulate=1, the product is then added to c_in, rounded toward zero. This is not a fused operation.
- Denormal inputs and results are flushed to signed zero.
- Exponent above 254 after rounding: result is ±Inf, overflow = 1.
- Nonzero exact result below the minimum normal: result is ±0, underflow = 1.
- Any NaN input, Inf×0, or Inf + (−Inf): result 0x7FC00000, flags 0.
- Inf operands otherwise propagate as IEEE with flags 0.
- Exact zero result: +0, unless both addends are −0.

Other:
- The upper bits of a_in/b_in not used by the selected format are ignored for arithmetic but still forwarded on a_out/b_out.
- Changing data_type between cycles takes effect immediately; W is not reinterpreted or cleared.
- Reset asserted mid-stream clears all state immediately. The first enabled edge after rst_n rises operates normally.

Test Plan:
- Reset → all outputs 0. Then enable=1, INT8, a=5, b=3, load_weight=1, accumulate=0 → next cycle c_out=15, a_out=5, b_out=3.
- Accumulation: W=3 held, a=2, accumulate=1, c_in fed back from c_out for 100 cycles starting at 15 → c_out=615, no flags. Also INT8 a=0xFE (−2), W=3 → c_out=0xFFFFFFFA.
- INT saturation:
  - c_in=0x7FFFFFF0, a=127, W=127, accumulate=1 → c_out=0x7FFFFFFF, overflow=1 for one cycle.
  - c_in=0x80000005, a=0x81 (−127), W=127 → c_out=0x80000000, underflow=1.
- FP: FP32 a=0x40400000, b=0x40000000, load_weight=1 → c_out=0x40C00000 (6.0). FP16 a=0x4200, b=0x4000 → c_out=0x40C00000.
- FP edge cases:
  - a=0x7F000000, W=0x7F000000 → c_out=0x7F800000, overflow=1.
  - a=0x00800000, W=0x3F000000 → c_out=0, underflow=1.
  - NaN input → 0x7FC00000.
- Control:
  - enable=0 for 5 cycles with changing inputs → outputs hold, flags 0.
  - load_weight every 10th cycle of 1000 nonzero INT8 ops → each c_out = a_in × most recently loaded weight, nonzero.
